// File: rtl/cmd_link_pkg.sv
// cmd_link_pkg: definitions shared by the command-link host issuer, the node
// controller and the benches: opcode values, issuer state encoding, frame byte
// counts and an opcode classification helper.
package cmd_link_pkg;

    // Opcode values carried in the second frame byte as {5'b0, op}
    localparam logic [2:0] OpOutData1 = 3'd0;
    localparam logic [2:0] OpOutData2 = 3'd1;
    localparam logic [2:0] OpOutRes   = 3'd2;
    localparam logic [2:0] OpLoad     = 3'd3;
    localparam logic [2:0] OpLoadRes  = 3'd4;
    localparam logic [2:0] OpMul      = 3'd5;
    localparam logic [2:0] OpMulAdd   = 3'd6;
    localparam logic [2:0] OpNoOp     = 3'd7;

    // Payload bytes following the opcode for OUT_DATA1/OUT_DATA2
    localparam int unsigned DataBytes = 4;
    // Bytes returned by the node for OUT_RES
    localparam int unsigned RespBytes = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSendAddr,
        StSendOp,
        StSendData,
        StWaitResp,
        StFinish
    } issuer_state_e;

    // What follows the opcode byte on the link
    typedef enum logic [1:0] {
        PathData,
        PathResp,
        PathFinish
    } op_path_e;

    function automatic op_path_e op_path(input logic [2:0] op);
        op_path_e path;
        unique case (op)
            OpOutData1, OpOutData2:                         path = PathData;
            OpOutRes:                                       path = PathResp;
            OpLoad, OpLoadRes, OpMul, OpMulAdd, OpNoOp:     path = PathFinish;
        endcase
        return path;
    endfunction

endpackage

// File: rtl/tx_byte_pacer.sv
// tx_byte_pacer: launches bytes onto the UART transmitter byte interface.
// A requested byte goes out (tx_out=1 with tx_data, same cycle) when the
// transmitter is not busy and no strobe was issued in the previous cycle, so
// tx_busy is never trusted in the cycle right after a strobe and strobes are
// always at least two cycles apart.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req, req_byte   byte offered by the issuer FSM
//   ack             byte taken this cycle (equals tx_out)
//   tx_busy         transmitter busy
//   tx_data, tx_out byte and one-cycle strobe to the transmitter
module tx_byte_pacer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] req_byte,
    output logic       ack,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_out
);

    logic strobe_q;
    logic launch;

    always_comb begin
        launch  = req && !tx_busy && !strobe_q;
        tx_out  = launch;
        ack     = launch;
        tx_data = launch ? req_byte : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= launch;
        end
    end

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: host-side initiator for the byte-serial command link.
// Accepts one command, sends addr, {5'b0,op} and, for OUT_DATA1/2, the 32-bit
// payload MSB first. OUT_RES then collects RESP_BYTES bytes from the receiver
// into res_data (byte k at [8k+7:8k]) and pulses res_valid.
// Optional feature: define CMD_ISSUER_TIMEOUT_EN to abort a response after
// TIMEOUT_CYCLES cycles without a received byte (res_valid with res_err).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only when idle)
//   cmd_addr, cmd_op, cmd_data     command fields, captured at acceptance
//   tx_data, tx_out, tx_busy       UART transmitter byte interface
//   rx_data, rx_in                 UART receiver byte interface
//   res_data, res_valid, res_err   assembled OUT_RES response
//   done                           one-cycle pulse when a non-OUT_RES command is issued
module cmd_issuer
    import cmd_link_pkg::*;
#(
    parameter int unsigned RESP_BYTES = RespBytes
`ifdef CMD_ISSUER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [7:0]              cmd_addr,
    input  logic [2:0]              cmd_op,
    input  logic [31:0]             cmd_data,
    output logic [7:0]              tx_data,
    output logic                    tx_out,
    input  logic                    tx_busy,
    input  logic [7:0]              rx_data,
    input  logic                    rx_in,
    output logic [8*RESP_BYTES-1:0] res_data,
    output logic                    res_valid,
    output logic                    res_err,
    output logic                    done
);

    localparam logic [4:0] RxFull   = 5'(RESP_BYTES);
    localparam logic [3:0] DataLast = 4'(DataBytes - 1);

    issuer_state_e           state_q, state_d;
    logic [7:0]              addr_q, addr_d;
    logic [2:0]              op_q, op_d;
    logic [31:0]             data_q, data_d;
    logic [3:0]              tx_cnt_q, tx_cnt_d;
    logic [4:0]              rx_cnt_q, rx_cnt_d;
    logic [8*RESP_BYTES-1:0] res_q, res_d;

    logic       req;
    logic       ack;
    logic [7:0] req_byte;

`ifdef CMD_ISSUER_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

    tx_byte_pacer u_pacer (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_byte (req_byte),
        .ack      (ack),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_out   (tx_out)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        data_d    = data_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        res_d     = res_q;
        req       = 1'b0;
        req_byte  = 8'h00;
        cmd_ready = 1'b0;
        done      = 1'b0;
        res_valid = 1'b0;
        res_err   = 1'b0;
`ifdef CMD_ISSUER_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif

        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    op_d     = cmd_op;
                    data_d   = cmd_data;
                    tx_cnt_d = 4'd0;
                    rx_cnt_d = 5'd0;
                    state_d  = StSendAddr;
                end
            end

            StSendAddr: begin
                req      = 1'b1;
                req_byte = addr_q;
                if (ack) begin
                    state_d = StSendOp;
                end
            end

            StSendOp: begin
                req      = 1'b1;
                req_byte = {5'b0, op_q};
                if (ack) begin
                    case (op_path(op_q))
                        PathData: state_d = StSendData;
                        PathResp: begin
                            // rx_in in this cycle is dropped: capture starts next cycle
                            state_d  = StWaitResp;
                            res_d    = '0;
                            rx_cnt_d = 5'd0;
`ifdef CMD_ISSUER_TIMEOUT_EN
                            to_cnt_d = '0;
`endif
                        end
                        default:  state_d = StFinish;
                    endcase
                end
            end

            StSendData: begin
                req = 1'b1;
                case (tx_cnt_q[1:0])
                    2'd0:    req_byte = data_q[31:24];
                    2'd1:    req_byte = data_q[23:16];
                    2'd2:    req_byte = data_q[15:8];
                    default: req_byte = data_q[7:0];
                endcase
                if (ack) begin
                    if (tx_cnt_q == DataLast) begin
                        state_d = StFinish;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 4'd1;
                    end
                end
            end

            StWaitResp: begin
                if (rx_cnt_q == RxFull) begin
                    // Last byte was captured on the previous edge
                    res_valid = 1'b1;
                    state_d   = StIdle;
                end else if (rx_in) begin
                    for (int unsigned k = 0; k < RESP_BYTES; k++) begin
                        if (rx_cnt_q == 5'(k)) begin
                            res_d[8*k +: 8] = rx_data;
                        end
                    end
                    rx_cnt_d = rx_cnt_q + 5'd1;
`ifdef CMD_ISSUER_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
`ifdef CMD_ISSUER_TIMEOUT_EN
                else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                    res_valid = 1'b1;
                    res_err   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
`endif
            end

            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 8'h00;
            op_q     <= 3'd0;
            data_q   <= 32'h0;
            tx_cnt_q <= 4'd0;
            rx_cnt_q <= 5'd0;
            res_q    <= '0;
`ifdef CMD_ISSUER_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            data_q   <= data_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            res_q    <= res_d;
`ifdef CMD_ISSUER_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign res_data = res_q;

endmodule

// File: tb/tb_cmd_issuer.sv
// Bench for cmd_issuer: directed cases plus randomized commands, checked
// against a frame/response model built from the link rules.
module tb_cmd_issuer;
    import cmd_link_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_addr;
    logic [2:0]   cmd_op;
    logic [31:0]  cmd_data;
    logic [7:0]   tx_data;
    logic         tx_out;
    logic         tx_busy;
    logic [7:0]   rx_data;
    logic         rx_in;
    logic [127:0] res_data;
    logic         res_valid;
    logic         res_err;
    logic         done;

    always #5 clk = ~clk;

    cmd_issuer #(
        .RESP_BYTES(16)
`ifdef CMD_ISSUER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .tx_data   (tx_data),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .rx_data   (rx_data),
        .rx_in     (rx_in),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_err   (res_err),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation state filled by the monitor
    int           cyc = 0;
    logic [7:0]   tx_log[$];
    int           tx_cyc[$];
    int           last_strobe = -100;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           rv_cnt = 0;
    int           rv_cyc = 0;
    logic [127:0] rv_data = '0;
    logic         rv_err = 1'b0;
    int           last_rx_cyc = 0;
    int           busy_hold = 0;
    int           busy_left = 0;

    // Monitor: samples on the falling edge
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_out) begin
                check("busy_low_at_strobe", tx_busy, 1'b0);
                check("strobe_gap_ge2", 128'((cyc - last_strobe) >= 2), 128'd1);
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
                last_strobe = cyc;
                busy_left = busy_hold;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (res_valid) begin
                rv_cnt++;
                rv_cyc  = cyc;
                rv_data = res_data;
                rv_err  = res_err;
            end
            if (rx_in) last_rx_cyc = cyc;
        end
    end

    // Transmitter model: busy for busy_hold cycles after each strobe
    initial begin : tx_model
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_busy = (busy_left != 0);
            if (busy_left != 0) busy_left--;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_in   = 1'b1;
        step();
        rx_in   = 1'b0;
    endtask

    task automatic issue(input logic [7:0] a, input logic [2:0] op, input logic [31:0] d);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        check("cmd_ready_before_issue", cmd_ready, 1'b1);
        tx_log.delete();
        tx_cyc.delete();
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_op    = op;
        cmd_data  = d;
        step();
        // Fields must be ignored after acceptance
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
        cmd_op    = 3'($urandom);
        cmd_data  = $urandom;
    endtask

    task automatic wait_strobes(input int cnt);
        int n;
        n = 0;
        while (tx_log.size() < cnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("strobe_count_reached", 128'(tx_log.size() >= cnt), 128'd1);
    endtask

    // One full command against the model. seq_rx: response bytes 0..15 back to back.
    task automatic run_cmd(input logic [7:0] a, input logic [2:0] op, input logic [31:0] d,
                           input bit junk_rx, input bit seq_rx);
        logic [7:0]   exp_frame[$];
        logic [7:0]   rb[16];
        logic [127:0] exp_res;
        int           d0, r0, n, min_gap;
        d0 = done_cnt;
        r0 = rv_cnt;
        exp_frame.delete();
        exp_frame.push_back(a);
        exp_frame.push_back({5'b0, op});
        if (op == OpOutData1 || op == OpOutData2)
            for (int i = 0; i < 4; i++) exp_frame.push_back(8'(d >> (24 - 8 * i)));
        min_gap = (busy_hold + 1 > 2) ? busy_hold + 1 : 2;

        issue(a, op, d);
        if (junk_rx) rx_byte(8'hA5);

        if (op == OpOutRes) begin
            wait_strobes(2);
            step();
            exp_res = '0;
            for (int k = 0; k < 16; k++) begin
                rb[k] = seq_rx ? 8'(k) : 8'($urandom);
                exp_res[8*k +: 8] = rb[k];
                rx_byte(rb[k]);
                if (!seq_rx) repeat ($urandom_range(0, 2)) step();
            end
            n = 0;
            while (rv_cnt == r0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("res_valid_count", 128'(rv_cnt - r0), 128'd1);
            check("res_data", rv_data, exp_res);
            check("res_err_clear", rv_err, 1'b0);
            check("res_valid_latency", 128'(rv_cyc - last_rx_cyc), 128'd1);
            @(negedge clk);
            check("ready_after_resp", cmd_ready, 1'b1);
            check("no_done_for_out_res", 128'(done_cnt - d0), 128'd0);
        end else begin
            n = 0;
            while (done_cnt == d0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("done_count", 128'(done_cnt - d0), 128'd1);
            if (tx_cyc.size() > 0)
                check("done_after_last_byte", 128'(done_cyc - tx_cyc[tx_cyc.size()-1]), 128'd1);
            repeat (5) @(negedge clk);
            check("no_res_valid", 128'(rv_cnt - r0), 128'd0);
            check("single_done", 128'(done_cnt - d0), 128'd1);
        end

        check("frame_len", 128'(tx_log.size()), 128'(exp_frame.size()));
        for (int i = 0; i < exp_frame.size(); i++)
            if (i < tx_log.size()) check($sformatf("frame_byte%0d", i), tx_log[i], exp_frame[i]);
        for (int i = 1; i < tx_cyc.size(); i++)
            check("strobe_pacing", 128'((tx_cyc[i] - tx_cyc[i-1]) >= min_gap), 128'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] exp_res;
        logic [7:0]   op;
        int           n, r0;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'h00;
        cmd_op    = 3'd0;
        cmd_data  = 32'h0;
        rx_data   = 8'h00;
        rx_in     = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_tx_out", tx_out, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_res_data", res_data, 128'h0);
        rst = 1'b0;
        step();

        // 1: NO_OP
        busy_hold = 0;
        run_cmd(8'h05, OpNoOp, 32'h13572468, 1'b0, 1'b0);

        // 2: OUT_DATA1 with a slow transmitter
        busy_hold = 3;
        run_cmd(8'h00, OpOutData1, 32'hDEADBEEF, 1'b0, 1'b0);

        // 3: OUT_RES with an incrementing response
        busy_hold = 1;
        run_cmd(8'h22, OpOutRes, 32'h0, 1'b0, 1'b1);
        check("res_incrementing", rv_data, 128'h0F0E0D0C0B0A09080706050403020100);

        // 4: stray rx_in while idle and while sending the address
        rx_byte(8'h5A);
        run_cmd(8'h41, OpOutRes, 32'h0, 1'b1, 1'b0);

`ifdef CMD_ISSUER_TIMEOUT_EN
        // 5: response stalls after three bytes
        busy_hold = 0;
        r0 = rv_cnt;
        issue(8'h66, OpOutRes, 32'h0);
        wait_strobes(2);
        step();
        exp_res = '0;
        for (int k = 0; k < 3; k++) begin
            exp_res[8*k +: 8] = 8'(8'h30 + k);
            rx_byte(8'(8'h30 + k));
        end
        n = 0;
        while (rv_cnt == r0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_res_valid", 128'(rv_cnt - r0), 128'd1);
        check("timeout_res_err", rv_err, 1'b1);
        check("timeout_latency", 128'(rv_cyc - last_rx_cyc), 128'd100);
        check("timeout_partial_data", rv_data, exp_res);
        @(negedge clk);
        check("timeout_ready_next", cmd_ready, 1'b1);
        step();
`endif

        // 6: reset while sending payload bytes
        busy_hold = 0;
        issue(8'h3C, OpOutData1, 32'h12345678);
        wait_strobes(3);
        @(posedge clk);
        step();
        check("pre_reset_strobe", tx_out, 1'b1);
        rst = 1'b1;
        #1;
        check("reset_kills_strobe", tx_out, 1'b0);
        check("reset_tx_data", tx_data, 8'h00);
        step();
        step();
        rst = 1'b0;
        #1;
        check("ready_after_reset", cmd_ready, 1'b1);
        step();
        run_cmd(8'h77, OpOutData2, 32'hCAFEF00D, 1'b0, 1'b0);

        // Randomized commands
        for (int t = 0; t < 12; t++) begin
            busy_hold = $urandom_range(0, 3);
            op = 8'($urandom_range(0, 7));
            run_cmd(8'($urandom), op[2:0], $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
